datapath: RTL and testbench

Single-bus 32-bit CPU datapath: sixteen general registers, PC, IR, MAR, MDR, Y, 64-bit Z, HI/LO, and an ALU, all joined by one shared bus multiplexer. The block has no control unit. An external controller or bench sequences it cycle by cycle through the per-register drive/load strobes and `op_sel`. Debug "view" outputs expose internal registers for simulation.

---
 rtl/datapath_pkg.sv | 52 +++++
 rtl/datapath_alu.sv | 81 ++++++++
 rtl/datapath.sv | 218 +++++++++++++++++++++
 tb/tb_datapath.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_pkg
// Description : Shared definitions for the single-bus CPU datapath. Holds the
//               ALU op_sel encodings, the bus source list (declared in
//               priority order, highest first), and the C-constant
//               sign-extension helper.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned NUM_GPR = 16;
    localparam int unsigned OP_W    = 5;

    // ALU operation encodings
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
    localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    // Bus sources in priority order: the first active one wins.
    typedef enum logic [3:0] {
        SRC_GPR  = 4'd0,   // R0..R15, lowest index first
        SRC_HI   = 4'd1,
        SRC_LO   = 4'd2,
        SRC_ZHI  = 4'd3,
        SRC_ZLO  = 4'd4,
        SRC_PC   = 4'd5,
        SRC_MDR  = 4'd6,
        SRC_IN   = 4'd7,
        SRC_C    = 4'd8,
        SRC_MAR  = 4'd9,
        SRC_NONE = 4'd10
    } bus_src_e;

    // Immediate constant carried in IR[18:0], sign-extended to a word.
    function automatic logic [WORD_W-1:0] c_sign_ext(input logic [WORD_W-1:0] ir);
        return {{13{ir[18]}}, ir[18:0]};
    endfunction

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Combinational 64-bit-result ALU for the single-bus datapath.
//               A comes from Y, B from the bus. 32-bit operations leave the
//               upper half zero; mul produces a full signed product; div
//               places the quotient low and the remainder high.
// Ports       : A      in  32  first operand (Y register)
//               B      in  32  second operand (bus)
//               op     in  5   operation select
//               result out 64  {Zhi, Zlo} value
// Revision    : 1.0 - initial release
// ============================================================================
module alu
    import datapath_pkg::*;
(
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  op,
    output logic [63:0] result
);

    logic [4:0]         shamt;
    logic [63:0]        rot_l;
    logic [63:0]        rot_r;
    logic signed [31:0] sra_val;
    logic signed [63:0] product;
    logic signed [31:0] divisor;
    logic signed [31:0] quotient;
    logic signed [31:0] remainder;
    logic               div_ovf;

    assign shamt = B[4:0];

    // Rotates are done on a doubled word so a zero shift amount needs no
    // special case.
    assign rot_l = {A, A} << shamt;
    assign rot_r = {A, A} >> shamt;

    assign sra_val = $signed(A) >>> shamt;

    assign product = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

    // The divider never sees zero; the zero-divisor result is forced below.
    // The single overflowing case (most negative / -1) is pinned explicitly
    // so the result does not depend on how the simulator treats it.
    assign divisor = (B == 32'd0) ? 32'sd1 : $signed(B);
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    always_comb begin
        if (div_ovf) begin
            quotient  = $signed(A);
            remainder = 32'sd0;
        end else begin
            quotient  = $signed(A) / divisor;
            remainder = $signed(A) % divisor;
        end
    end

    always_comb begin
        result = 64'd0;
        case (op)
            OP_ADD:  result = {32'd0, A + B};
            OP_SUB:  result = {32'd0, A - B};
            OP_SHR:  result = {32'd0, A >> shamt};
            OP_SHRA: result = {32'd0, sra_val};
            OP_SHL:  result = {32'd0, A << shamt};
            OP_ROR:  result = {32'd0, rot_r[31:0]};
            OP_ROL:  result = {32'd0, rot_l[63:32]};
            OP_AND:  result = {32'd0, A & B};
            OP_OR:   result = {32'd0, A | B};
            OP_MUL:  result = product;
            OP_DIV:  result = (B == 32'd0) ? 64'd0 : {remainder, quotient};
            OP_NEG:  result = {32'd0, 32'd0 - B};
            OP_NOT:  result = {32'd0, ~B};
            default: result = 64'd0;
        endcase
    end

endmodule : alu
`default_nettype wire

// File: rtl/datapath.sv
`default_nettype none
// ============================================================================
// Module      : datapath
// Description : Single-bus 32-bit CPU datapath with no control unit. Sixteen
//               general registers, PC, IR, MAR, MDR, Y, 64-bit Z and HI/LO
//               share one priority bus multiplexer; an external sequencer
//               drives the per-register strobes and op_sel every cycle.
// Ports       : clk        in   1   system clock, rising edge
//               clr        in   1   asynchronous active-low reset
//               R_rd       in   16  per-register load from bus
//               R_wrt      in   16  per-register drive onto bus
//               *_out      in   1   bus drive selects (HI, LO, Zhi, Zlo, PC,
//                                   MDR, MAR, In, C)
//               *_rd       in   1   load enables (MAR, Zlo, PC, MDR, IR, Y)
//               IncPC      in   1   PC increment
//               Read       in   1   MDR source: 1 = Mdatain, 0 = bus
//               op_sel     in   5   ALU operation
//               Mdatain    in   32  memory read data
//               BusMuxOut  out  32  current bus value
//               *_view     out  32  debug views of internal registers
//               Data_view  out  32  IR contents
// Revision    : 1.0 - initial release
// ============================================================================
module datapath
    import datapath_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] R_rd,
    input  logic [15:0] R_wrt,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        Zhi_out,
    input  logic        Zlo_out,
    input  logic        PC_out,
    input  logic        MDR_out,
    input  logic        MAR_out,
    input  logic        In_out,
    input  logic        C_out,
    input  logic        MAR_rd,
    input  logic        Zlo_rd,
    input  logic        PC_rd,
    input  logic        MDR_rd,
    input  logic        IR_rd,
    input  logic        Y_rd,
    input  logic        IncPC,
    input  logic        Read,
    input  logic [4:0]  op_sel,
    input  logic [31:0] Mdatain,
    output logic [31:0] BusMuxOut,
    output logic [31:0] r3_view,
    output logic [31:0] r4_view,
    output logic [31:0] r7_view,
    output logic [31:0] Y_view,
    output logic [31:0] Zlo_view,
    output logic [31:0] MDR_view,
    output logic [31:0] PC_view,
    output logic [31:0] Data_view
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0] gpr [NUM_GPR];
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mar;
    logic [31:0] mdr;
    logic [31:0] y;
    logic [63:0] z;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] bus;
    logic [63:0] alu_result;

    // ------------------------------------------------------------------
    // Bus multiplexer: pick the highest-priority active source, then
    // steer its value. Every sink loads the pre-edge bus value, so a
    // register may drive and load in the same cycle.
    // ------------------------------------------------------------------
    bus_src_e    src;
    logic [3:0]  gpr_idx;

    always_comb begin
        gpr_idx = 4'd0;
        // Scan downward so the lowest active index is the one that sticks.
        for (int i = NUM_GPR - 1; i >= 0; i--) begin
            if (R_wrt[i]) begin
                gpr_idx = i[3:0];
            end
        end
    end

    always_comb begin
        src = SRC_NONE;
        if      (|R_wrt)  src = SRC_GPR;
        else if (HI_out)  src = SRC_HI;
        else if (LO_out)  src = SRC_LO;
        else if (Zhi_out) src = SRC_ZHI;
        else if (Zlo_out) src = SRC_ZLO;
        else if (PC_out)  src = SRC_PC;
        else if (MDR_out) src = SRC_MDR;
        else if (In_out)  src = SRC_IN;
        else if (C_out)   src = SRC_C;
        else if (MAR_out) src = SRC_MAR;
    end

    always_comb begin
        bus = 32'd0;
        case (src)
            SRC_GPR:  bus = gpr[gpr_idx];
            SRC_HI:   bus = hi;
            SRC_LO:   bus = lo;
            SRC_ZHI:  bus = z[63:32];
            SRC_ZLO:  bus = z[31:0];
            SRC_PC:   bus = pc;
            SRC_MDR:  bus = mdr;
            SRC_IN:   bus = 32'd0;          // input port reserved
            SRC_C:    bus = c_sign_ext(ir);
            SRC_MAR:  bus = mar;
            default:  bus = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU: A = Y, B = bus
    // ------------------------------------------------------------------
    alu u_alu (
        .A      (y),
        .B      (bus),
        .op     (op_sel),
        .result (alu_result)
    );

    // ------------------------------------------------------------------
    // General registers R0..R15
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    gpr[g] <= 32'd0;
                end else if (R_rd[g]) begin
                    gpr[g] <= bus;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Special registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ir  <= 32'd0;
            mar <= 32'd0;
            y   <= 32'd0;
        end else begin
            if (IR_rd)  ir  <= bus;
            if (MAR_rd) mar <= bus;
            if (Y_rd)   y   <= bus;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mdr <= 32'd0;
        end else if (MDR_rd) begin
            mdr <= Read ? Mdatain : bus;
        end
    end

    // A bus load takes precedence over the increment.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc <= 32'd0;
        end else if (PC_rd) begin
            pc <= bus;
        end else if (IncPC) begin
            pc <= pc + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            z <= 64'd0;
        end else if (Zlo_rd) begin
            z <= alu_result;
        end
    end

    // HI/LO have no load path yet; they sit at their reset value.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else begin
            hi <= hi;
            lo <= lo;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign BusMuxOut = bus;
    assign r3_view   = gpr[3];
    assign r4_view   = gpr[4];
    assign r7_view   = gpr[7];
    assign Y_view    = y;
    assign Zlo_view  = z[31:0];
    assign MDR_view  = mdr;
    assign PC_view   = pc;
    assign Data_view = ir;

endmodule : datapath
`default_nettype wire

// File: tb/tb_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath
// Description : Directed self-checking bench for the single-bus datapath.
//               Steps the datapath through moves, an ALU subtract sequence,
//               PC behaviour, IR/C, mul/div/shift/rotate and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath;

    logic        clk;
    logic        clr;
    logic [15:0] R_rd;
    logic [15:0] R_wrt;
    logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out;
    logic        In_out, C_out;
    logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd;
    logic        IncPC, Read;
    logic [4:0]  op_sel;
    logic [31:0] Mdatain;
    logic [31:0] BusMuxOut;
    logic [31:0] r3_view, r4_view, r7_view, Y_view, Zlo_view, MDR_view, PC_view;
    logic [31:0] Data_view;

    int tests  = 0;
    int failed = 0;

    datapath dut (
        .clk       (clk),
        .clr       (clr),
        .R_rd      (R_rd),
        .R_wrt     (R_wrt),
        .HI_out    (HI_out),
        .LO_out    (LO_out),
        .Zhi_out   (Zhi_out),
        .Zlo_out   (Zlo_out),
        .PC_out    (PC_out),
        .MDR_out   (MDR_out),
        .MAR_out   (MAR_out),
        .In_out    (In_out),
        .C_out     (C_out),
        .MAR_rd    (MAR_rd),
        .Zlo_rd    (Zlo_rd),
        .PC_rd     (PC_rd),
        .MDR_rd    (MDR_rd),
        .IR_rd     (IR_rd),
        .Y_rd      (Y_rd),
        .IncPC     (IncPC),
        .Read      (Read),
        .op_sel    (op_sel),
        .Mdatain   (Mdatain),
        .BusMuxOut (BusMuxOut),
        .r3_view   (r3_view),
        .r4_view   (r4_view),
        .r7_view   (r7_view),
        .Y_view    (Y_view),
        .Zlo_view  (Zlo_view),
        .MDR_view  (MDR_view),
        .PC_view   (PC_view),
        .Data_view (Data_view)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        R_rd = '0; R_wrt = '0;
        HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
        MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
        MAR_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0;
        IncPC = 0; Read = 0; op_sel = '0; Mdatain = '0;
    endtask

    // One clock edge, then settle and drop every strobe.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic mdr_in(input logic [31:0] v);
        Mdatain = v; Read = 1; MDR_rd = 1;
        step();
    endtask

    // Y <- a, then Z <- ALU(Y, b) with b driven from MDR.
    task automatic alu_run(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        mdr_in(a);
        MDR_out = 1; Y_rd = 1;
        step();
        mdr_in(b);
        MDR_out = 1; op_sel = op; Zlo_rd = 1;
        step();
    endtask

    task automatic check_zhi(input string tag, input logic [31:0] exp);
        Zhi_out = 1;
        #1;
        check(tag, BusMuxOut, exp);
        Zhi_out = 0;
    endtask

    initial begin
        idle();
        clr = 1'b0;
        #12;
        check("reset_pc", PC_view, 32'd0);
        check("reset_bus", BusMuxOut, 32'd0);
        #1 clr = 1'b1;
        @(negedge clk);

        // MDR load from memory, then move to R3
        mdr_in(32'h50);
        check("mdr_load", MDR_view, 32'h50);
        MDR_out = 1; R_rd[3] = 1;
        #1;
        check("bus_mdr", BusMuxOut, 32'h50);
        step();
        check("r3_move", r3_view, 32'h50);

        // R4 = 0x14, R7 = 0x17
        mdr_in(32'h14); MDR_out = 1; R_rd[4] = 1; step();
        check("r4_load", r4_view, 32'h14);
        mdr_in(32'h17); MDR_out = 1; R_rd[7] = 1; step();
        check("r7_load", r7_view, 32'h17);

        // Subtract R3 - R7 into R4
        R_wrt[3] = 1; Y_rd = 1; step();
        check("sub_y", Y_view, 32'h50);
        R_wrt[7] = 1; op_sel = 5'b00100; Zlo_rd = 1; step();
        check("sub_zlo", Zlo_view, 32'h39);
        check_zhi("sub_zhi", 32'd0);
        Zlo_out = 1; R_rd[4] = 1; step();
        check("sub_r4", r4_view, 32'h39);

        // Bus priority: lowest register index, then PC over MDR, idle is 0
        R_wrt = 16'h0088; #1;
        check("prio_gpr", BusMuxOut, 32'h39 + 32'h17 - 32'h39 + 32'h39); // R3 = 0x50
        idle(); PC_out = 1; MDR_out = 1; #1;
        check("prio_pc_mdr", BusMuxOut, 32'd0);
        idle(); R_wrt[7] = 1; MDR_out = 1; #1;
        check("prio_gpr_mdr", BusMuxOut, 32'h17);
        idle(); #1;
        check("bus_idle", BusMuxOut, 32'd0);

        // PC behaviour
        IncPC = 1; step();
        check("pc_inc", PC_view, 32'd1);
        mdr_in(32'h07); MDR_out = 1; PC_rd = 1; step();
        check("pc_load", PC_view, 32'd7);
        mdr_in(32'h100); MDR_out = 1; PC_rd = 1; IncPC = 1; step();
        check("pc_load_wins", PC_view, 32'h100);
        mdr_in(32'hFFFF_FFFF); MDR_out = 1; PC_rd = 1; step();
        IncPC = 1; step();
        check("pc_wrap", PC_view, 32'd0);

        // MAR round trip
        mdr_in(32'hDEAD_BEEF); MDR_out = 1; MAR_rd = 1; step();
        MAR_out = 1; #1;
        check("mar_bus", BusMuxOut, 32'hDEAD_BEEF);
        idle();

        // IR and C constant: IR[18:0] of 0x021A3800 is 0x23800, bit 18 clear
        mdr_in(32'h021A_3800); MDR_out = 1; IR_rd = 1; step();
        check("ir_load", Data_view, 32'h021A_3800);
        C_out = 1; #1;
        check("c_pos", BusMuxOut, 32'h0002_3800);
        idle();
        // IR[18:0] of 0x12345678 is 0x45678, bit 18 set -> negative
        mdr_in(32'h1234_5678); MDR_out = 1; IR_rd = 1; step();
        C_out = 1; #1;
        check("c_neg", BusMuxOut, 32'hFFFC_5678);
        idle();
        In_out = 1; #1;
        check("in_zero", BusMuxOut, 32'd0);
        idle();

        // Multiply, divide, shifts, rotates
        alu_run(32'hFFFF_FFFA, 32'd4, 5'b01111);
        check("mul_lo", Zlo_view, 32'hFFFF_FFE8);
        check_zhi("mul_hi", 32'hFFFF_FFFF);
        alu_run(32'd7, 32'd2, 5'b10000);
        check("div_q", Zlo_view, 32'd3);
        check_zhi("div_r", 32'd1);
        alu_run(32'hFFFF_FFF9, 32'd2, 5'b10000);
        check("divn_q", Zlo_view, 32'hFFFF_FFFD);
        check_zhi("divn_r", 32'hFFFF_FFFF);
        alu_run(32'd7, 32'd0, 5'b10000);
        check("div0_lo", Zlo_view, 32'd0);
        check_zhi("div0_hi", 32'd0);
        alu_run(32'd1, 32'd1, 5'b01000);
        check("ror", Zlo_view, 32'h8000_0000);
        alu_run(32'h8000_0001, 32'd4, 5'b01001);
        check("rol", Zlo_view, 32'h0000_0018);
        alu_run(32'h8000_0000, 32'd4, 5'b00110);
        check("shra", Zlo_view, 32'hF800_0000);
        alu_run(32'h8000_0000, 32'd4, 5'b00101);
        check("shr", Zlo_view, 32'h0800_0000);
        alu_run(32'h0000_0003, 32'd33, 5'b00111);
        check("shl_mod32", Zlo_view, 32'h0000_0006);
        alu_run(32'hFFFF_FFFF, 32'd1, 5'b00011);
        check("add_wrap", Zlo_view, 32'd0);
        check_zhi("add_hi", 32'd0);
        alu_run(32'hF0F0_1234, 32'h0FF0_FF00, 5'b01010);
        check("and", Zlo_view, 32'h00F0_1200);
        alu_run(32'hF0F0_1234, 32'h0FF0_FF00, 5'b01011);
        check("or", Zlo_view, 32'hFFF0_FF34);
        alu_run(32'd0, 32'd5, 5'b10001);
        check("neg", Zlo_view, 32'hFFFF_FFFB);
        alu_run(32'd0, 32'h0000_FFFF, 5'b10010);
        check("not", Zlo_view, 32'hFFFF_0000);
        alu_run(32'd9, 32'd9, 5'b00000);
        check("op_unused", Zlo_view, 32'd0);

        // Asynchronous reset mid-operation; reset beats a pending load
        mdr_in(32'h55);
        MDR_out = 1; Y_rd = 1; IncPC = 1; R_rd[3] = 1;
        #2 clr = 1'b0;
        #1;
        check("rst_mdr", MDR_view, 32'd0);
        check("rst_pc", PC_view, 32'd0);
        check("rst_r3", r3_view, 32'd0);
        check("rst_ir", Data_view, 32'd0);
        @(posedge clk); #1;
        check("rst_hold_y", Y_view, 32'd0);
        check("rst_hold_pc", PC_view, 32'd0);
        idle();
        clr = 1'b1;
        step();
        check("rel_zlo", Zlo_view, 32'd0);
        check("rel_r7", r7_view, 32'd0);
        check("rel_r4", r4_view, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_datapath
`default_nettype wire
